vending_machine: RTL and testbench



---
 rtl/vending_machine.sv | 121 ++++++++++++
 tb/tb_vending_machine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// -----------------------------------------------------------------------------
// vending_machine
//
// Coin-operated vending controller for a single product priced at 15 units.
// It accepts at most one coin per clock (5 or 10 units) and keeps the running
// credit as an FSM state (S0 / S5 / S10). When the credit reaches 15 or more
// it vends and returns to S0 on the same edge. An overpayment of 5 units is
// returned through the change output.
//
// Ports:
//   clk     in   1  system clock, rising-edge active
//   rst     in   1  asynchronous, active-high reset (clears credit, no refund)
//   in      in   2  coin: 00 none, 01 = 5, 10 = 10, 11 invalid (ignored)
//   out     out  1  registered dispense pulse
//   change  out  2  registered change pulse: 00 none, 01 = 5 units back
//                   (10 = 10 units is reserved and never produced)
// -----------------------------------------------------------------------------
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam logic [1:0] CHANGE_NONE = 2'b00;
  localparam logic [1:0] CHANGE_5    = 2'b01;

  state_t     state_q, state_d;
  logic       out_q, out_d;
  logic [1:0] change_q, change_d;

  // Next-state and next-output logic. Outputs default to "no vend" so that
  // every non-vending edge clears them. This includes invalid coins and
  // unreachable state encodings.
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    change_d = CHANGE_NONE;

    case (state_q)
      S0: begin
        if (in == COIN_5) begin
          state_d = S5;
        end else if (in == COIN_10) begin
          state_d = S10;
        end
      end

      S5: begin
        if (in == COIN_5) begin
          state_d = S10;
        end else if (in == COIN_10) begin
          state_d = S0;
          out_d   = 1'b1;
        end
      end

      S10: begin
        if (in == COIN_5) begin
          state_d = S0;
          out_d   = 1'b1;
        end else if (in == COIN_10) begin
          // 20 units paid against a 15-unit price: hand back 5.
          state_d  = S0;
          out_d    = 1'b1;
          change_d = CHANGE_5;
        end
      end

      // The unused encoding (2'b11) falls back to an empty credit with quiet
      // outputs.
      default: begin
        state_d = S0;
      end
    endcase

    // An invalid coin never changes anything. It is handled explicitly, so
    // the hold does not depend on the decode above happening to skip 2'b11.
    if (in != COIN_NONE && in != COIN_5 && in != COIN_10 &&
        (state_q == S0 || state_q == S5 || state_q == S10)) begin
      state_d  = state_q;
      out_d    = 1'b0;
      change_d = CHANGE_NONE;
    end
  end

  // Credit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered dispense/change pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= 1'b0;
      change_q <= CHANGE_NONE;
    end else begin
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  assign out    = out_q;
  assign change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// -----------------------------------------------------------------------------
// tb_vending_machine
//
// Directed bench for vending_machine. A behavioural model tracks the credit
// as a plain integer. On each edge it adds the coin value. When the credit
// reaches 15 it vends and returns (credit - 15) as change. A compare process
// checks the DUT outputs against this model on every falling edge. Each
// directed step also checks a hand-computed literal expectation.
// -----------------------------------------------------------------------------
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  int checks;
  int errors;

  // Model state
  int         m_credit;
  logic       m_out;
  logic [1:0] m_change;

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the credit is kept as an integer in units.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_credit = 0;
      m_out    = 1'b0;
      m_change = 2'b00;
    end else begin
      if (in == 2'b01)      m_credit = m_credit + 5;
      else if (in == 2'b10) m_credit = m_credit + 10;
      if (m_credit >= 15) begin
        m_out    = 1'b1;
        m_change = 2'((m_credit - 15) / 5);
        m_credit = 0;
      end else begin
        m_out    = 1'b0;
        m_change = 2'b00;
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    checks++;
    if (out !== m_out || change !== m_change) begin
      errors++;
      $display("FAIL model_cmp t=%0t: out=%b change=%b, model wants out=%b change=%b",
               $time, out, change, m_out, m_change);
    end
  end

  task automatic check_lit(input string name, input logic exp_out,
                           input logic [1:0] exp_chg);
    checks++;
    if (out !== exp_out || change !== exp_chg) begin
      errors++;
      $display("FAIL %s t=%0t: out=%b change=%b, expected out=%b change=%b",
               name, $time, out, change, exp_out, exp_chg);
    end
  endtask

  // Present one coin for one edge, then check the registered result.
  task automatic step(input string name, input logic [1:0] coin,
                      input logic exp_out, input logic [1:0] exp_chg);
    @(negedge clk);
    in = coin;
    @(posedge clk);
    #1;
    $display("txn %-8s in=%b -> out=%b change=%b (expect %b %b)",
             name, coin, out, change, exp_out, exp_chg);
    check_lit(name, exp_out, exp_chg);
  endtask

  // Assert reset between edges. The outputs must clear without a clock edge.
  task automatic mid_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in  = 2'bxx;
    #1;
    $display("txn %-8s rst=1 -> out=%b change=%b", name, out, change);
    check_lit(name, 1'b0, 2'b00);
    #3;
    rst = 1'b0;
    in  = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_credit = 0;
    m_out    = 1'b0;
    m_change = 2'b00;
    rst = 1'b0;

    // 1. Reset with the coin input undriven.
    #1;
    rst = 1'b1;
    #1;
    check_lit("rst_imm", 1'b0, 2'b00);
    #5;
    check_lit("rst_hold", 1'b0, 2'b00);
    rst = 1'b0;
    in  = 2'b00;
    $display("txn reset released");

    // 2. Three 5-unit coins, held; vends on every third edge.
    step("c5_e1", 2'b01, 1'b0, 2'b00);
    step("c5_e2", 2'b01, 1'b0, 2'b00);
    step("c5_e3", 2'b01, 1'b1, 2'b00);
    step("c5_e4", 2'b01, 1'b0, 2'b00);
    step("c5_e5", 2'b01, 1'b0, 2'b00);
    step("c5_e6", 2'b01, 1'b1, 2'b00);
    step("idle", 2'b00, 1'b0, 2'b00);

    // 3. 5 then 10.
    step("t3_c5", 2'b01, 1'b0, 2'b00);
    step("t3_c10", 2'b10, 1'b1, 2'b00);
    step("t3_idle", 2'b00, 1'b0, 2'b00);

    // 4. 10 then 10 gives 5 units of change.
    step("t4_c10a", 2'b10, 1'b0, 2'b00);
    step("t4_c10b", 2'b10, 1'b1, 2'b01);
    step("t4_idle", 2'b00, 1'b0, 2'b00);

    // Back-to-back purchases: 10+10 followed directly by 5+10.
    step("bb_c10a", 2'b10, 1'b0, 2'b00);
    step("bb_c10b", 2'b10, 1'b1, 2'b01);
    step("bb_c5", 2'b01, 1'b0, 2'b00);
    step("bb_c10", 2'b10, 1'b1, 2'b00);

    // 5. Credit is held through idle and invalid coins.
    step("t5_c10", 2'b10, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) step("t5_idle", 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) step("t5_inv", 2'b11, 1'b0, 2'b00);
    step("t5_c5", 2'b01, 1'b1, 2'b00);
    step("t5_done", 2'b00, 1'b0, 2'b00);

    // 6. Reset mid-credit discards the 10 units.
    step("t6_c5a", 2'b01, 1'b0, 2'b00);
    step("t6_c5b", 2'b01, 1'b0, 2'b00);
    mid_reset("t6_rst");
    step("t6_c5c", 2'b01, 1'b0, 2'b00);
    step("t6_c10", 2'b10, 1'b1, 2'b00);

    // Reset while a vend pulse is showing.
    step("rv_c10a", 2'b10, 1'b0, 2'b00);
    step("rv_c10b", 2'b10, 1'b1, 2'b01);
    mid_reset("rv_rst");
    step("rv_idle", 2'b00, 1'b0, 2'b00);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
